vector_load_unit: RTL and testbench
===================================

Name: vector_load_unit

Overview:
- Writer-side companion to the vector register file.
- Gathers one vector (vecSize lanes of regSize bits) from scalar-wide data memory, one lane per request.
- Then issues a single-cycle write (regWrEn/regToWrite/regWriteData) into the register file.
- Sits in the memory/writeback stage of the SIMD pipeline and serves vector-load instructions.

Parameters:
- regSize, 16, bits per lane (memory data width).
- selBits, 2, width of register select.
- vecSize, 4, lanes per vector.
- addrBits, 16, memory address width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a vector load; sampled only in IDLE.
- baseAddr  input  addrBits  address of lane 0; latched on accepted start.
- destReg  input  selBits  destination vector register; latched on accepted start.
- memRdEn  output  1  one-cycle read request strobe.
- memAddr  output  addrBits  read address, valid while memRdEn=1.
- memValid  input  1  read data valid, arrives any number of cycles (>=1) after memRdEn.
- memRdData  input  regSize  read data, qualified by memValid.
- regWrEn  output  1  register-file write enable, one-cycle pulse.
- regToWrite  output  selBits  destination register index.
- regWriteData  output  [vecSize-1:0][regSize-1:0]  assembled vector; lane j from baseAddr+j.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse, coincident with regWrEn.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - State is IDLE, lane counter is 0, lane buffer is all zeros.
  - memRdEn=0, memAddr=0, regWrEn=0, regToWrite=0, regWriteData=0, busy=0, done=0.
- Outputs: all outputs are registered and stable for the whole cycle. This is required because the register file gates its clock with regWrEn.
- FSM states: IDLE, REQ, WAIT, WRITE.
  - IDLE: when start=1, latch baseAddr and destReg, clear the lane counter, go to REQ. When start=0, stay in IDLE.
  - REQ: memRdEn=1 and memAddr=base+lane for exactly one cycle, then go to WAIT.
  - WAIT: memRdEn=0; hold until memValid=1.
    - On memValid=1, capture memRdData into buffer[lane].
    - If lane==vecSize-1, go to WRITE; otherwise increment lane and go to REQ.
  - WRITE: regWrEn=1, done=1, regToWrite=latched destReg, regWriteData=buffer; then go to IDLE.
- Outstanding requests: at most one read is outstanding at any time.
- Latency: with memValid exactly one cycle after each memRdEn, regWrEn is high 2*vecSize+1 cycles after the cycle in which start was sampled (9 cycles at the defaults).
- Address arithmetic: base+lane is computed modulo 2^addrBits, so the address wraps from 0xFFFF to 0x0000.
- regWriteData after a write: holds the last buffer contents (no clearing). The buffer is overwritten lane by lane during the next load.
- Boundary conditions:
  - start while busy is ignored. It is neither queued nor does it relatch baseAddr/destReg.
  - memValid in IDLE, REQ or WRITE is ignored and does not alter the buffer.
  - memValid in the same cycle as memRdEn (REQ) is ignored; data is accepted only in WAIT.
  - start in the WRITE cycle is ignored; a new start is accepted from the following IDLE cycle.
  - Back-to-back loads: minimum spacing is one IDLE cycle between done and the next accepted start.
  - reset asserted mid-operation returns the block immediately to IDLE with all outputs at their reset values. No partial write is ever issued.

Decomposition:
- Shared package (simd_pkg) holds:
  - the vload_state_t enum (IDLE, REQ, WAIT, WRITE);
  - default constants REG_SIZE=16, VEC_SIZE=4, SEL_BITS=2, ADDR_BITS=16.
- One sub-module is natural: vector_lane_buffer.
  - vecSize x regSize storage with asynchronous reset.
  - Per-lane write enable, driven by a decoder on lane; it reuses logic_decoder.
  - Full-vector parallel output.

Test Plan:
- Basic load: memory[0x0100..0x0103]=0x1111,0x2222,0x3333,0x4444; start with baseAddr=0x0100, destReg=2; memValid 1 cycle after each request -> memAddr sequence 0x0100..0x0103, then a single regWrEn/done pulse 9 cycles after start, with regToWrite=2 and regWriteData={0x4444,0x3333,0x2222,0x1111}.
- Variable memory latency: memValid delayed 3, 1, 5, 2 cycles -> exactly 4 memRdEn pulses, never two outstanding, same assembled vector, busy high throughout.
- Address wrap: baseAddr=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Ignored inputs: start pulsed with destReg=1 mid-load, plus a spurious memValid in REQ -> original destReg retained, buffer unaffected, only one write issued.
- Reset mid-load: assert reset while in WAIT of lane 2 -> outputs zero immediately, no regWrEn; a subsequent fresh load completes correctly.
- Back-to-back: second start on the first IDLE cycle after done, with destReg=3 -> second write correct, first write's data unaffected.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared types and default sizing for the SIMD datapath blocks.
package simd_pkg;

    localparam int REG_SIZE  = 16;
    localparam int VEC_SIZE  = 4;
    localparam int SEL_BITS  = 2;
    localparam int ADDR_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } vload_state_t;

    // Width of a counter that indexes `lanes` lanes; never narrower than one bit.
    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/logic_decoder.sv
// Binary-to-one-hot decoder with a global enable.
module logic_decoder #(
    parameter int IN_BITS = 2
) (
    input  logic                       en,
    input  logic [IN_BITS-1:0]         sel,
    output logic [(1 << IN_BITS)-1:0]  onehot
);

    generate
        for (genvar gi = 0; gi < (1 << IN_BITS); gi++) begin : g_out
            assign onehot[gi] = en && (sel == IN_BITS'(gi));
        end
    endgenerate

endmodule

// File: rtl/vector_lane_buffer.sv
// Per-lane storage for a vector being gathered; one lane written per cycle.
module vector_lane_buffer
    import simd_pkg::*;
#(
    parameter int regSize  = REG_SIZE,
    parameter int vecSize  = VEC_SIZE,
    parameter int laneBits = lane_bits(VEC_SIZE)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [laneBits-1:0]              wr_lane,
    input  logic [regSize-1:0]               wr_data,
    output logic [vecSize-1:0][regSize-1:0]  data_out
);

    logic [(1 << laneBits)-1:0] lane_sel;

    logic_decoder #(
        .IN_BITS (laneBits)
    ) u_lane_decoder (
        .en     (wr_en),
        .sel    (wr_lane),
        .onehot (lane_sel)
    );

    generate
        for (genvar gi = 0; gi < vecSize; gi++) begin : g_lane
            logic [regSize-1:0] lane_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (lane_sel[gi]) begin
                    lane_reg <= wr_data;
                end
            end

            assign data_out[gi] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/vector_load_unit.sv
// Gathers one vector from scalar memory, one lane per read, then writes it
// to the vector register file with a single registered write pulse.
module vector_load_unit
    import simd_pkg::*;
#(
    parameter int regSize  = REG_SIZE,
    parameter int selBits  = SEL_BITS,
    parameter int vecSize  = VEC_SIZE,
    parameter int addrBits = ADDR_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [addrBits-1:0]              baseAddr,
    input  logic [selBits-1:0]               destReg,
    output logic                             memRdEn,
    output logic [addrBits-1:0]              memAddr,
    input  logic                             memValid,
    input  logic [regSize-1:0]               memRdData,
    output logic                             regWrEn,
    output logic [selBits-1:0]               regToWrite,
    output logic [vecSize-1:0][regSize-1:0]  regWriteData,
    output logic                             busy,
    output logic                             done
);

    localparam int                  LANE_BITS = lane_bits(vecSize);
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(vecSize - 1);

    vload_state_t          state_reg;
    logic [LANE_BITS-1:0]  lane_reg;
    logic [LANE_BITS-1:0]  lane_next;
    logic [addrBits-1:0]   base_reg;
    logic [selBits-1:0]    dest_reg;
    logic [addrBits-1:0]   mem_addr_reg;
    logic [selBits-1:0]    reg_to_write_reg;
    logic                  mem_rd_en_reg;
    logic                  reg_wr_en_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  capture;

    assign lane_next = lane_reg + 1'b1;

    // Read data is only accepted while a request is outstanding.
    assign capture = (state_reg == WAIT) && memValid;

    vector_lane_buffer #(
        .regSize  (regSize),
        .vecSize  (vecSize),
        .laneBits (LANE_BITS)
    ) u_lane_buffer (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (capture),
        .wr_lane  (lane_reg),
        .wr_data  (memRdData),
        .data_out (regWriteData)
    );

    // Every output is a flop so the register file sees glitch-free strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            lane_reg         <= '0;
            base_reg         <= '0;
            dest_reg         <= '0;
            mem_addr_reg     <= '0;
            reg_to_write_reg <= '0;
            mem_rd_en_reg    <= 1'b0;
            reg_wr_en_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            mem_rd_en_reg <= 1'b0;
            reg_wr_en_reg <= 1'b0;
            done_reg      <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg      <= baseAddr;
                        dest_reg      <= destReg;
                        lane_reg      <= '0;
                        mem_addr_reg  <= baseAddr;
                        mem_rd_en_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= REQ;
                    end
                end

                REQ: begin
                    state_reg <= WAIT;
                end

                WAIT: begin
                    if (memValid) begin
                        if (lane_reg == LAST_LANE) begin
                            reg_wr_en_reg    <= 1'b1;
                            done_reg         <= 1'b1;
                            reg_to_write_reg <= dest_reg;
                            state_reg        <= WRITE;
                        end else begin
                            // Address arithmetic wraps naturally at addrBits.
                            lane_reg      <= lane_next;
                            mem_addr_reg  <= base_reg + addrBits'(lane_next);
                            mem_rd_en_reg <= 1'b1;
                            state_reg     <= REQ;
                        end
                    end
                end

                WRITE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign memRdEn    = mem_rd_en_reg;
    assign memAddr    = mem_addr_reg;
    assign regWrEn    = reg_wr_en_reg;
    assign regToWrite = reg_to_write_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_vector_load_unit.sv
// Scoreboard bench for vector_load_unit: a memory responder with scripted
// latencies, expected reads/writes queued at stimulus time, checked by a monitor.
module tb_vector_load_unit;

    logic                clk;
    logic                reset;
    logic                start;
    logic [15:0]         baseAddr;
    logic [1:0]          destReg;
    logic                memRdEn;
    logic [15:0]         memAddr;
    logic                memValid;
    logic [15:0]         memRdData;
    logic                regWrEn;
    logic [1:0]          regToWrite;
    logic [3:0][15:0]    regWriteData;
    logic                busy;
    logic                done;

    vector_load_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .baseAddr     (baseAddr),
        .destReg      (destReg),
        .memRdEn      (memRdEn),
        .memAddr      (memAddr),
        .memValid     (memValid),
        .memRdData    (memRdData),
        .regWrEn      (regWrEn),
        .regToWrite   (regToWrite),
        .regWriteData (regWriteData),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [1:0]  dest;
        logic [63:0] data;
        int          start_cyc;
        bit          chk_lat;
    } wr_exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rd_seen  = 0;
    int          lat_q[$];
    logic [15:0] exp_addr_q[$];
    wr_exp_t     exp_wr_q[$];
    bit          inject_spurious = 0;
    logic [15:0] mem [0:65535];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: answers each read after a scripted latency (default 1).
    initial begin
        int          pend;
        logic [15:0] pend_addr;
        pend      = 0;
        pend_addr = '0;
        memValid  = 1'b0;
        memRdData = '0;
        forever begin
            @(negedge clk);
            memValid = 1'b0;
            if (reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        memValid  = 1'b1;
                        memRdData = mem[pend_addr];
                    end
                end
                if (memRdEn) begin
                    rd_seen++;
                    chk("one_outstanding", pend, 0);
                    if (inject_spurious) begin
                        memValid        = 1'b1;
                        memRdData       = 16'hDEAD;
                        inject_spurious = 0;
                    end
                    pend      = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
                    pend_addr = memAddr;
                end
            end
        end
    end

    // Monitor: compares every read request and every register write.
    always @(negedge clk) begin
        if (!reset) begin
            if (memRdEn) begin
                chk("rd_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) begin
                    logic [15:0] ea;
                    ea = exp_addr_q.pop_front();
                    chk("mem_addr", memAddr, ea);
                    $display("RD  addr=%h exp=%h", memAddr, ea);
                end
            end
            if (regWrEn) begin
                chk("wr_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) begin
                    wr_exp_t e;
                    e = exp_wr_q.pop_front();
                    chk("reg_to_write", regToWrite, e.dest);
                    chk("reg_write_data", regWriteData, e.data);
                    if (e.chk_lat) chk("wr_latency", cyc - e.start_cyc, 9);
                    $display("WR  reg=%0d data=%h", regToWrite, regWriteData);
                end
            end
            if (done !== regWrEn) chk("done_with_wren", done, regWrEn);
        end
    end

    task automatic start_load(input logic [15:0] base, input logic [1:0] dest,
                              input bit want_wr, input logic [63:0] data, input bit chk_lat);
        wr_exp_t e;
        @(negedge clk);
        chk("idle_before_start", busy, 0);
        baseAddr = base;
        destReg  = dest;
        start    = 1'b1;
        if (want_wr) begin
            e.dest      = dest;
            e.data      = data;
            e.start_cyc = cyc;
            e.chk_lat   = chk_lat;
            exp_wr_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        bit busy_ok;
        n       = 0;
        busy_ok = 1;
        while (!done) begin
            if (!busy) busy_ok = 0;
            if (n == 200) break;
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done, 1);
        chk("busy_during_load", busy_ok, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_memRdEn"}, memRdEn, 0);
        chk({tag, "_memAddr"}, memAddr, 0);
        chk({tag, "_regWrEn"}, regWrEn, 0);
        chk({tag, "_regToWrite"}, regToWrite, 0);
        chk({tag, "_regWriteData"}, regWriteData, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int r0;
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        destReg  = '0;
        mem[16'h0100] = 16'h1111; mem[16'h0101] = 16'h2222;
        mem[16'h0102] = 16'h3333; mem[16'h0103] = 16'h4444;
        mem[16'hFFFE] = 16'hA0A0; mem[16'hFFFF] = 16'hB1B1;
        mem[16'h0000] = 16'hC2C2; mem[16'h0001] = 16'hD3D3;
        mem[16'h0200] = 16'h5555; mem[16'h0201] = 16'h6666;
        mem[16'h0202] = 16'h7777; mem[16'h0203] = 16'h8888;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Basic load, unit latency
        exp_addr_q.push_back(16'h0100); exp_addr_q.push_back(16'h0101);
        exp_addr_q.push_back(16'h0102); exp_addr_q.push_back(16'h0103);
        start_load(16'h0100, 2'd2, 1, 64'h4444_3333_2222_1111, 1);
        wait_done();

        // Variable memory latency
        lat_q = '{3, 1, 5, 2};
        exp_addr_q.push_back(16'h0100); exp_addr_q.push_back(16'h0101);
        exp_addr_q.push_back(16'h0102); exp_addr_q.push_back(16'h0103);
        start_load(16'h0100, 2'd2, 1, 64'h4444_3333_2222_1111, 0);
        wait_done();

        // Address wrap
        exp_addr_q.push_back(16'hFFFE); exp_addr_q.push_back(16'hFFFF);
        exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0001);
        start_load(16'hFFFE, 2'd1, 1, 64'hD3D3_C2C2_B1B1_A0A0, 1);
        wait_done();

        // Ignored start mid-load and spurious memValid during REQ
        inject_spurious = 1;
        exp_addr_q.push_back(16'h0100); exp_addr_q.push_back(16'h0101);
        exp_addr_q.push_back(16'h0102); exp_addr_q.push_back(16'h0103);
        start_load(16'h0100, 2'd0, 1, 64'h4444_3333_2222_1111, 1);
        repeat (2) @(negedge clk);
        baseAddr = 16'h0200;
        destReg  = 2'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);

        // Reset while waiting on lane 2
        lat_q = '{1, 1, 6};
        exp_addr_q.push_back(16'h0100); exp_addr_q.push_back(16'h0101);
        exp_addr_q.push_back(16'h0102);
        r0 = rd_seen;
        start_load(16'h0100, 2'd3, 0, 64'h0, 0);
        n = 0;
        while (rd_seen < r0 + 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_lane2", rd_seen - r0, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        lat_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        exp_addr_q.push_back(16'hFFFE); exp_addr_q.push_back(16'hFFFF);
        exp_addr_q.push_back(16'h0000); exp_addr_q.push_back(16'h0001);
        start_load(16'hFFFE, 2'd1, 1, 64'hD3D3_C2C2_B1B1_A0A0, 1);
        wait_done();

        // Back-to-back: second start on the first IDLE cycle after done
        exp_addr_q.push_back(16'h0100); exp_addr_q.push_back(16'h0101);
        exp_addr_q.push_back(16'h0102); exp_addr_q.push_back(16'h0103);
        start_load(16'h0100, 2'd2, 1, 64'h4444_3333_2222_1111, 1);
        wait_done();
        exp_addr_q.push_back(16'h0200); exp_addr_q.push_back(16'h0201);
        exp_addr_q.push_back(16'h0202); exp_addr_q.push_back(16'h0203);
        start_load(16'h0200, 2'd3, 1, 64'h8888_7777_6666_5555, 1);
        wait_done();

        repeat (10) @(negedge clk);
        chk("rd_queue_drained", exp_addr_q.size(), 0);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
